// File: rtl/yc_wrr_lock_arb.sv
// Weighted round-robin arbiter with packet lock: each owner gets up to weight[i]
// packets per turn, and a grant is pinned from a packet's first flit to its last flit.
module yc_wrr_lock_arb #(
  parameter int unsigned N  = 5,
  parameter int unsigned WW = 4,
  localparam int unsigned PW = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_i,
  input  logic [N-1:0]      last_i,
  input  logic [N*WW-1:0]   weight_i,
  input  logic              ready_i,
  output logic [N-1:0]      gnt_o,
  output logic [PW-1:0]     gnt_idx_o,
  output logic              xfer_o,
  output logic              locked_o
);

  localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

  typedef enum logic {
    ST_OPEN = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [WW-1:0]   cnt_q, cnt_d;

  logic            scan_hit;
  logic [PW-1:0]   scan_idx;
  logic [PW-1:0]   cand;
  logic            g_any;
  logic [PW-1:0]   g_idx;
  logic [WW-1:0]   g_wt;
  logic [WW-1:0]   effw;
  logic [WW-1:0]   used;
  logic [PW-1:0]   nxt_ptr;
  logic            xfer_c;

  // Rotating priority scan starting at ptr, wrapping modulo N
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    cand     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = PW'((32'(ptr_q) + k) % N);
      if (!scan_hit && req_i[cand]) begin
        scan_hit = 1'b1;
        scan_idx = cand;
      end
    end
  end

  // A locked owner keeps the grant even while its request is low
  always_comb begin
    g_any = scan_hit;
    g_idx = scan_idx;
    if (state_q == ST_LOCK) begin
      g_any = 1'b1;
      g_idx = ptr_q;
    end
  end

  always_comb begin
    g_wt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (PW'(i) == g_idx) begin
        g_wt = weight_i[i*WW +: WW];
      end
    end
  end

  assign effw    = (g_wt == '0) ? WW'(1) : g_wt;
  assign used    = (g_idx == ptr_q) ? (cnt_q + WW'(1)) : WW'(1);
  assign nxt_ptr = (g_idx == LAST_IDX) ? '0 : (g_idx + PW'(1));
  assign xfer_c  = g_any & req_i[g_idx] & ready_i;

  assign gnt_o     = g_any ? (N'(1) << g_idx) : '0;
  assign gnt_idx_o = g_any ? g_idx : '0;
  assign xfer_o    = xfer_c;
  assign locked_o  = (state_q == ST_LOCK);

  // Next-state: state only moves on a transferred flit
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (xfer_c) begin
      if (!last_i[g_idx]) begin
        state_d = ST_LOCK;
        ptr_d   = g_idx;
        if (g_idx != ptr_q) begin
          cnt_d = '0;
        end
      end else begin
        state_d = ST_OPEN;
        if (used >= effw) begin
          ptr_d = nxt_ptr;
          cnt_d = '0;
        end else begin
          ptr_d = g_idx;
          cnt_d = used;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OPEN;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_yc_wrr_lock_arb.sv
// Directed bench for yc_wrr_lock_arb: per-cycle comparison against a packet-level
// model of the weighted turn rules, plus hand-computed grant sequences.
module tb_yc_wrr_lock_arb;

  localparam int N  = 5;
  localparam int WW = 4;
  localparam int PW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    last = '0;
  logic [N*WW-1:0] weight = '0;
  logic            ready = 1'b0;
  logic [N-1:0]    gnt;
  logic [PW-1:0]   gnt_idx;
  logic            xfer;
  logic            locked;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: current turn owner, whether a packet is mid-flight, packets done this turn
  int m_head = 0;
  bit m_busy = 1'b0;
  int m_done = 0;

  yc_wrr_lock_arb #(.N(N), .WW(WW)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .last_i(last), .weight_i(weight),
    .ready_i(ready), .gnt_o(gnt), .gnt_idx_o(gnt_idx), .xfer_o(xfer), .locked_o(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_g();
    int g;
    g = -1;
    if (m_busy) g = m_head;
    else begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && req[(m_head + k) % N]) g = (m_head + k) % N;
      end
    end
    return g;
  endfunction

  function automatic int model_w(input int g);
    int w;
    w = int'(weight[g*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    int done;
    if (!rst_n) begin
      m_head = 0;
      m_busy = 1'b0;
      m_done = 0;
    end else begin
      g = model_g();
      if (g >= 0 && req[g] && ready) begin
        if (!last[g]) begin
          if (g != m_head) m_done = 0;
          m_head = g;
          m_busy = 1'b1;
        end else begin
          done = (g == m_head) ? m_done + 1 : 1;
          m_busy = 1'b0;
          if (done >= model_w(g)) begin
            m_head = (g + 1) % N;
            m_done = 0;
          end else begin
            m_head = g;
            m_done = done;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    int g;
    g = model_g();
    chk("m_gnt", int'(gnt), (g >= 0) ? (1 << g) : 0);
    chk("m_gnt_idx", int'(gnt_idx), (g >= 0) ? g : 0);
    chk("m_xfer", int'(xfer), (g >= 0 && req[g] && ready) ? 1 : 0);
    chk("m_locked", int'(locked), int'(m_busy));
  end

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l, input logic rd,
                     input int exp_idx, input logic exp_x, input logic exp_lk, input string name);
    req = r;
    last = l;
    ready = rd;
    @(negedge clk);
    #1;
    chk({name, "_idx"}, int'(gnt_idx), (exp_idx < 0) ? 0 : exp_idx);
    chk({name, "_gnt"}, int'(gnt), (exp_idx < 0) ? 0 : (1 << exp_idx));
    chk({name, "_xfer"}, int'(xfer), int'(exp_x));
    chk({name, "_lock"}, int'(locked), int'(exp_lk));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req = '0;
    last = '0;
    ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int rot_seq[6] = '{0, 1, 2, 3, 4, 0};
  int wt_seq[10] = '{0, 0, 0, 1, 2, 3, 4, 0, 0, 0};

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_locked", int'(locked), 0);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_idx", int'(gnt_idx), 0);
    chk("rst_xfer", int'(xfer), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic rotation, all weights 1, single-flit packets
    weight = {4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    for (int i = 0; i < 6; i++) cyc(5'b11111, 5'b11111, 1'b1, rot_seq[i], 1'b1, 1'b0, "rot");

    // Weighted turn: requester 0 has weight 3
    do_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd1, 4'd3};
    for (int i = 0; i < 10; i++) cyc(5'b11111, 5'b11111, 1'b1, wt_seq[i], 1'b1, 1'b0, "wt");

    // Lock with back-pressure: 3-flit packet from 0, stall on flit 2
    do_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    cyc(5'b00011, 5'b00000, 1'b1, 0, 1'b1, 1'b0, "lk_f1");
    cyc(5'b00011, 5'b00000, 1'b0, 0, 1'b0, 1'b1, "lk_stall");
    cyc(5'b00011, 5'b00000, 1'b1, 0, 1'b1, 1'b1, "lk_f2");
    cyc(5'b00011, 5'b00001, 1'b1, 0, 1'b1, 1'b1, "lk_f3");
    cyc(5'b00011, 5'b00010, 1'b1, 1, 1'b1, 1'b0, "lk_next");
    // Request drop mid-packet keeps the grant with no transfer
    cyc(5'b00011, 5'b00000, 1'b1, 0, 1'b1, 1'b0, "drop_f1");
    cyc(5'b00010, 5'b00000, 1'b1, 0, 1'b0, 1'b1, "drop_gap");
    cyc(5'b00011, 5'b00001, 1'b1, 0, 1'b1, 1'b1, "drop_f2");
    cyc(5'b00010, 5'b00010, 1'b1, 1, 1'b1, 1'b0, "drop_next");

    // Zero weight behaves as one packet per turn
    do_reset();
    weight = {4'd1, 4'd1, 4'd0, 4'd1, 4'd1};
    for (int i = 0; i < 6; i++) cyc(5'b11111, 5'b11111, 1'b1, rot_seq[i], 1'b1, 1'b0, "w0");

    // Forfeit: requester 2 (weight 4) drops after one packet, count restarts later
    do_reset();
    weight = {4'd1, 4'd1, 4'd4, 4'd1, 4'd1};
    cyc(5'b00100, 5'b00100, 1'b1, 2, 1'b1, 1'b0, "ff_a");
    cyc(5'b01000, 5'b01000, 1'b1, 3, 1'b1, 1'b0, "ff_b");
    for (int i = 0; i < 4; i++) cyc(5'b01100, 5'b01100, 1'b1, 2, 1'b1, 1'b0, "ff_turn");
    cyc(5'b01100, 5'b01100, 1'b1, 3, 1'b1, 1'b0, "ff_end");

    // Asynchronous reset mid-packet with ptr=3
    do_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    cyc(5'b01000, 5'b00000, 1'b1, 3, 1'b1, 1'b0, "rm_f1");
    chk("rm_pre_lock", int'(locked), 1);
    req = 5'b11000;
    last = '0;
    ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rm_locked", int'(locked), 0);
    chk("rm_idx", int'(gnt_idx), 3);
    chk("rm_xfer", int'(xfer), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    weight = {4'd1, 4'd1, 4'd2, 4'd1, 4'd1};
    cyc(5'b11000, 5'b11000, 1'b1, 3, 1'b1, 1'b0, "rm_after");
    cyc(5'b11000, 5'b11000, 1'b1, 4, 1'b1, 1'b0, "rm_after2");

    // Wrap: ptr=4, only requester 0 asks, then the scan restarts at 1
    do_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    cyc(5'b01000, 5'b01000, 1'b1, 3, 1'b1, 1'b0, "wr_set");
    cyc(5'b00001, 5'b00001, 1'b1, 0, 1'b1, 1'b0, "wr_0");
    cyc(5'b10011, 5'b10011, 1'b1, 1, 1'b1, 1'b0, "wr_1");
    cyc(5'b00000, 5'b00000, 1'b1, -1, 1'b0, 1'b0, "idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/yc_wrr_lock_arb.md
# yc_wrr_lock_arb

Parametrised weighted round-robin arbiter with packet lock, the successor to the plain N-way round-robin arbiter in the NoC router output stage. Each requester receives up to `weight[i]` consecutive packets per turn, and a grant is held from the first flit of a packet through its `last` flit, regardless of competing requests. It uses a valid/ready transfer model against a single downstream port and sits between the input-port VC selectors and the output crossbar.

## Interface
- `N`, default 5: number of requesters; N ≥ 2.
- `WW`, default 4: weight and credit-counter width.
- `PW`, derived: `(N<=2)?1:$clog2(N)`, the index width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req`  in  N  per-requester flit valid.
- `last`  in  N  per-requester tail flag; qualified by `req[i]`.
- `weight`  in  N*WW  packets per turn; slice i is `[i*WW +: WW]`. A value of 0 is treated as 1.
- `ready`  in  1  downstream accepts a flit this cycle.
- `gnt`  out  N  one-hot grant, or all zero.
- `gnt_idx`  out  PW  index of the granted requester; 0 when `gnt` is zero.
- `xfer`  out  1  flit transferred this cycle: `|(gnt & req) & ready`.
- `locked`  out  1  a packet is in flight; the grant is pinned.

## Operation
- State registers: `ptr` (PW bits, the priority head / current owner), `lock` (1 bit), `cnt` (WW bits, packets already completed by the owner in this turn).
- Grant is combinational from state and `req`:
  - `lock`=1: `gnt` = onehot(`ptr`). The grant is held even if `req[ptr]` drops, and `xfer` stays 0 until `req[ptr]` returns.
  - `lock`=0: scan `ptr, ptr+1, … ptr+N-1` modulo N and grant the first set `req`. `gnt`=0 if `req`=0.
- Let `g` be the granted index and `effw = (weight[g]==0) ? 1 : weight[g]`, sampled at the completing transfer.
- On `xfer` with `last[g]`=0:
  - `lock`<=1, `ptr`<=g.
  - `cnt`<=0 if g≠`ptr`, else `cnt` unchanged.
- On `xfer` with `last[g]`=1, compute `used` = (g==`ptr`) ? `cnt`+1 : 1. Then:
  - `lock`<=0.
  - If `used` ≥ `effw`: `ptr`<=(g+1)%N, `cnt`<=0 (turn ends).
  - Else: `ptr`<=g, `cnt`<=`used` (the owner keeps priority).
- A single-flit packet (`last`=1 on its first flit) never sets `lock`.
- Forfeit: when `lock`=0 and `req[ptr]`=0, the scan picks another requester. That requester becomes the new owner on its transfer with `cnt` restarted, and the remaining credit of the old owner is discarded.
- No `xfer`: all state holds.
- Width rules:
  - `cnt` never exceeds `effw-1` ≤ 2^WW−2, so there is no overflow.
  - `ptr` wraps N-1 → 0 by modulo N, not by power of 2.
- Requester rule: once `req[i]` is asserted it stays high until the flit transfers. While `lock`=0 and `ready`=0, a newly raised request that is earlier in scan order may take the grant. This is legal because no flit has moved yet.

## Timing
- Request to grant: 0 cycles (combinational). Grant to state update: the next rising `clk` edge after `xfer`.
- Throughput: one flit per cycle. There is no bubble between packets or between owners.
- Reset (`rst_n`=0, asynchronous, at any time including mid-packet):
  - `ptr`=0, `lock`=0, `cnt`=0.
  - `locked`=0.
  - `gnt`/`gnt_idx`/`xfer` then follow `req` combinationally from `ptr`=0, so with `req`=0 they are 0/0/0.
- Reset release is synchronous to the first rising edge with `rst_n`=1. The in-flight packet is lost, and the upstream logic must also be reset.
- `locked` = `lock` register, registered with no combinational path from inputs.

## Test plan
- **Basic rotation.** N=5, all weights 1, `req`=5'b11111, `last`=all 1, `ready`=1 → `gnt_idx` sequence 0,1,2,3,4,0 across 6 cycles, with `xfer`=1 every cycle.
- **Weighted turn.** `weight[0]`=3, others 1, all requesting single-flit packets → `gnt_idx` 0,0,0,1,2,3,4,0,0,0.
- **Lock with back-pressure.** `req`=5'b00011; requester 0 sends a 3-flit packet (`last` on flit 3); `ready`=0 during the cycle of flit 2 → `gnt`=5'b00001 for 4 cycles with `locked`=1 from after flit 1 through flit 3, then `gnt_idx`=1. Dropping `req[0]` for one cycle mid-packet leaves `gnt`=5'b00001 with `xfer`=0.
- **Zero weight and forfeit.**
  - `weight[2]`=0 → requester 2 gets one packet per turn.
  - `weight[2]`=4, requester 2 completes 1 packet, then drops `req`, with `req[3]` high → next `gnt_idx`=3. When 2 re-requests, its count restarts from 1.
- **Reset mid-packet.** With `locked`=1 and `ptr`=3, assert `rst_n`=0 between edges → `locked` falls immediately. With `req`=5'b11000, `gnt_idx`=3 from the scan starting at 0, and `cnt`=0.
- **Wrap.** `ptr`=4, `req`=5'b00001 → `gnt_idx`=0. After its `last` transfer with weight 1, the next scan starts at 1.
